rib_mem_slave: RTL and testbench

RIB_MEM_SLAVE -- requirements
Module: rib_mem_slave

---
 rtl/rib_mem_slave.sv | 160 ++++++++++++++++
 tb/tb_rib_mem_slave.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/rib_mem_slave.sv
`default_nettype none
// ============================================================================
// Module      : rib_mem_slave
// Description : Word-addressed memory slave on a simple request/acknowledge
//               bus. A request is captured in IDLE. The FSM then spends
//               WAIT_CYCLES wait states in WAIT and gives a single-cycle
//               response in RESP. Storage is DEPTH_WORDS x 32 bits with
//               byte-enable writes. Storage is never cleared by reset.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk      in   1  rising-edge clock
//   rst_n    in   1  asynchronous active-low reset
//   req_i    in   1  request valid, held until ack_o
//   we_i     in   1  1 = write, 0 = read
//   addr_i   in  32  byte address
//   wdata_i  in  32  write data
//   wstrb_i  in   4  byte enables
//   ack_o    out  1  one-cycle completion pulse
//   rdata_o  out 32  read data, valid with ack_o
//   err_o    out  1  error flag, valid with ack_o
//   busy_o   out  1  FSM not in IDLE
// ============================================================================
module rib_mem_slave #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        busy_o
);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_wait = 2'd1;
  localparam logic [1:0] c_resp = 2'd2;

  // The counter is loaded with WAIT_CYCLES-1 so that WAIT runs for
  // exactly WAIT_CYCLES cycles: it leaves WAIT on the cycle the counter is 0.
  localparam logic [3:0]  c_cnt_load = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam int          c_idx_w    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] c_depth    = 32'(DEPTH_WORDS);

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic [3:0]          r_cnt;
  logic                r_we;
  logic [31:0]         r_addr;
  logic [31:0]         r_wdata;
  logic [3:0]          r_wstrb;
  logic [31:0]         r_mem [DEPTH_WORDS];
  logic [c_idx_w-1:0]  w_idx;
  logic                w_addr_err;
  logic                w_accept;
  logic                w_commit;
  logic [31:0]         w_mem_word;

  assign w_accept   = (r_state == c_idle) && req_i;
  assign w_idx      = r_addr[c_idx_w+1:2];
  // The error is raised for a misaligned address or for a word index past
  // the end of the array.
  assign w_addr_err = (r_addr[1:0] != 2'b00) || ({2'b00, r_addr[31:2]} >= c_depth);
  assign w_mem_word = r_mem[w_idx];
  // Writes land on the edge that ends RESP. An asynchronous reset drops the
  // FSM out of RESP immediately, so an aborted write never reaches this edge.
  assign w_commit   = (r_state == c_resp) && r_we && !w_addr_err && rst_n;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_idle: begin
        if (req_i) begin
          w_state_nxt = (WAIT_CYCLES == 0) ? c_resp : c_wait;
        end
      end
      c_wait: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = c_resp;
        end
      end
      c_resp:  w_state_nxt = c_idle;
      default: w_state_nxt = c_idle;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic. The outputs are decoded from state alone, so reset clears
  // them at once.
  // --------------------------------------------------------------------------
  always_comb begin
    ack_o   = 1'b0;
    err_o   = 1'b0;
    rdata_o = 32'h0;
    busy_o  = (r_state != c_idle);
    if (r_state == c_resp) begin
      ack_o = 1'b1;
      err_o = w_addr_err;
      if (!r_we && !w_addr_err) begin
        rdata_o = w_mem_word;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Request capture and wait counter. Bus inputs are ignored outside IDLE.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_wstrb <= 4'h0;
    end else if (w_accept) begin
      r_cnt   <= c_cnt_load;
      r_we    <= we_i;
      r_addr  <= addr_i;
      r_wdata <= wdata_i;
      r_wstrb <= wstrb_i;
    end else if ((r_state == c_wait) && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Storage array. It has no reset so that it maps onto plain RAM.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (r_wstrb[b]) begin
          r_mem[w_idx][8*b +: 8] <= r_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rib_mem_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_rib_mem_slave
// Description : Directed self-checking bench for rib_mem_slave. It drives a
//               WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rib_mem_slave;

  localparam int C_WAIT  = 2;
  localparam int C_DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_i = 1'b0, we_i = 1'b0;
  logic [31:0] addr_i = 32'h0, wdata_i = 32'h0;
  logic [3:0]  wstrb_i = 4'h0;
  logic        ack_o, err_o, busy_o;
  logic [31:0] rdata_o;

  logic        z_req = 1'b0, z_we = 1'b0;
  logic [31:0] z_addr = 32'h0, z_wdata = 32'h0;
  logic [3:0]  z_wstrb = 4'h0;
  logic        z_ack, z_err, z_busy;
  logic [31:0] z_rdata;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [31:0] model [C_DEPTH];
  logic [32:0] exp_q [$];

  rib_mem_slave #(.DEPTH_WORDS(C_DEPTH), .WAIT_CYCLES(C_WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .wstrb_i(wstrb_i), .ack_o(ack_o), .rdata_o(rdata_o),
    .err_o(err_o), .busy_o(busy_o)
  );

  rib_mem_slave #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_i(z_req), .we_i(z_we), .addr_i(z_addr),
    .wdata_i(z_wdata), .wstrb_i(z_wstrb), .ack_o(z_ack), .rdata_o(z_rdata),
    .err_o(z_err), .busy_o(z_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction on the WAIT_CYCLES=2 instance. The expected response is
  // queued from the reference model when the stimulus is driven. It is popped
  // when ack_o appears. Bus inputs are scrambled during WAIT to show that only
  // the captured copies are used.
  task automatic txn(input logic t_we, input logic [31:0] t_addr, input logic [31:0] t_wdata,
                     input logic [3:0] t_wstrb, output logic [31:0] t_rd);
    logic        e_err;
    logic [31:0] e_rd;
    logic [32:0] e;
    int          acc;
    int          n;
    bit          got;
    e_err = (t_addr[1:0] != 2'b00) || (t_addr[31:2] >= 30'(C_DEPTH));
    e_rd  = (t_we || e_err) ? 32'h0 : model[t_addr[11:2]];
    exp_q.push_back({e_err, e_rd});
    if (t_we && !e_err) begin
      for (int b = 0; b < 4; b++)
        if (t_wstrb[b]) model[t_addr[11:2]][8*b +: 8] = t_wdata[8*b +: 8];
    end
    t_rd = 32'h0;
    @(negedge clk);
    check("idle_before_req", busy_o, 1'b0);
    req_i = 1'b1; we_i = t_we; addr_i = t_addr; wdata_i = t_wdata; wstrb_i = t_wstrb;
    @(posedge clk); #1;
    acc = cyc;
    check("busy_after_accept", busy_o, 1'b1);
    we_i = ~t_we; addr_i = $urandom; wdata_i = $urandom; wstrb_i = 4'hF;
    got = 1'b0;
    n = 0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (ack_o === 1'b1) got = 1'b1;
    end
    check("ack_seen", 32'(got), 32'd1);
    e = exp_q.pop_front();
    if (got) begin
      check("ack_latency", 32'(cyc - acc + 1), 32'(C_WAIT + 1));
      check("rdata", rdata_o, e[31:0]);
      check("err", err_o, e[32]);
      t_rd = rdata_o;
      req_i = 1'b0;
      @(negedge clk);
      check("ack_one_cycle", ack_o, 1'b0);
    end
    req_i = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    int          ack_at [3];
    int          n_ack;
    int          acc;
    int          ack_cyc;
    int          busy_cnt;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst_ack", ack_o, 1'b0);
    check("rst_err", err_o, 1'b0);
    check("rst_rdata", rdata_o, 32'h0);
    check("rst_busy", busy_o, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Seed words used later
    txn(1'b1, 32'h0000_0000, 32'h0102_0304, 4'hF, rd);
    txn(1'b1, 32'h0000_0008, 32'h1234_5678, 4'hF, rd);
    txn(1'b1, 32'h0000_0004, 32'h0BAD_CAFE, 4'hF, rd);

    // Write then read
    txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, rd);
    txn(1'b0, 32'h0000_0010, 32'h0, 4'h0, rd);
    check("wr_rd_const", rd, 32'hDEAD_BEEF);

    // Byte strobes
    txn(1'b1, 32'h0000_0010, 32'h1122_3344, 4'h5, rd);
    txn(1'b0, 32'h0000_0010, 32'h0, 4'h0, rd);
    check("strobe_const", rd, 32'hDE22_BE44);

    // Zero strobe modifies nothing
    txn(1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'h0, rd);
    txn(1'b0, 32'h0000_0010, 32'h0, 4'h0, rd);
    check("zero_strobe_const", rd, 32'hDE22_BE44);

    // Errors: misaligned read, out-of-range write, word 0 untouched
    txn(1'b0, 32'h0000_0013, 32'h0, 4'h0, rd);
    txn(1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 4'hF, rd);
    txn(1'b0, 32'h0000_0000, 32'h0, 4'h0, rd);
    check("err_wr_no_effect", rd, 32'h0102_0304);

    // Held request: back-to-back reads of 0x4
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h4; wdata_i = 32'h0; wstrb_i = 4'h0;
    for (int k = 0; k < 3; k++) exp_q.push_back({1'b0, model[1]});
    n_ack = 0;
    ack_at[0] = 0; ack_at[1] = 0; ack_at[2] = 0;
    for (int k = 0; k < 60 && n_ack < 3; k++) begin
      @(negedge clk);
      if (ack_o === 1'b1) begin
        ack_at[n_ack] = cyc;
        check("held_rdata", rdata_o, exp_q.pop_front()
              [31:0]);
        n_ack++;
        if (n_ack == 3) req_i = 1'b0;
      end
    end
    req_i = 1'b0;
    exp_q.delete();
    check("held_ack_count", 32'(n_ack), 32'd3);
    check("held_spacing_1", 32'(ack_at[1] - ack_at[0]), 32'(C_WAIT + 2));
    check("held_spacing_2", 32'(ack_at[2] - ack_at[1]), 32'(C_WAIT + 2));
    @(negedge clk);
    check("held_ack_low", ack_o, 1'b0);

    // Reset during WAIT aborts the write
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h8; wdata_i = 32'hA5A5_A5A5; wstrb_i = 4'hF;
    @(posedge clk); #1;
    check("abort_in_wait", busy_o, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    req_i = 1'b0;
    #1;
    check("abort_rst_ack", ack_o, 1'b0);
    check("abort_rst_err", err_o, 1'b0);
    check("abort_rst_rdata", rdata_o, 32'h0);
    check("abort_rst_busy", busy_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    n_ack = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ack_o === 1'b1) n_ack++;
    end
    check("abort_no_ack", 32'(n_ack), 32'd0);
    txn(1'b0, 32'h0000_0008, 32'h0, 4'h0, rd);
    check("abort_old_value", rd, 32'h1234_5678);
    txn(1'b0, 32'h0000_0010, 32'h0, 4'h0, rd);
    check("mem_survives_reset", rd, 32'hDE22_BE44);

    // WAIT_CYCLES=0 instance: write, read, and an out-of-range read
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      z_req = 1'b1;
      z_we = (t == 0);
      z_addr = (t == 2) ? 32'h0000_0100 : 32'h0;
      z_wdata = 32'hCAFE_F00D;
      z_wstrb = 4'hF;
      @(posedge clk); #1;
      acc = cyc;
      ack_cyc = -1;
      busy_cnt = 0;
      rd = 32'h0;
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        if (z_busy === 1'b1) busy_cnt++;
        if (z_ack === 1'b1 && ack_cyc < 0) begin
          ack_cyc = cyc;
          rd = z_rdata;
          check("w0_err", z_err, (t == 2) ? 1'b1 : 1'b0);
          z_req = 1'b0;
        end
      end
      z_req = 1'b0;
      check("w0_latency", 32'(ack_cyc - acc + 1), 32'd1);
      check("w0_busy_cycles", 32'(busy_cnt), 32'd1);
      check("w0_rdata", rd, (t == 1) ? 32'hCAFE_F00D : 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
